// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round constants, S-box table and
// the combinational round-datapath functions (SubBytes, ShiftRows,
// MixColumns, AddRoundKey).
// Byte order is FIPS-197: byte 0 sits in bits [0:7] of a [0:127] block, and
// state byte r + 4*c is row r, column c.
package aes_pkg;

    localparam int unsigned BLK_W      = 128;
    localparam int unsigned NUM_ROUNDS = 10;
    localparam logic [7:0]  RCON_INIT  = 8'h01;

    typedef logic [0:BLK_W-1] blk_t;

    typedef enum logic [1:0] {
        AES_IDLE  = 2'd0,
        AES_ROUND = 2'd1,
        AES_FINAL = 2'd2,
        AES_DONE  = 2'd3
    } aes_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic blk_t sub_bytes(input blk_t s);
        blk_t o;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = SBOX[s[8*i +: 8]];
        end
        return o;
    endfunction

    // Row r rotates left by r columns.
    function automatic blk_t shift_rows(input blk_t s);
        blk_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c + r) % 4)) +: 8];
            end
        end
        return o;
    endfunction

    function automatic blk_t mix_columns(input blk_t s);
        blk_t       o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(4*c)     +: 8];
            a1 = s[8*(4*c + 1) +: 8];
            a2 = s[8*(4*c + 2) +: 8];
            a3 = s[8*(4*c + 3) +: 8];
            o[8*(4*c)     +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[8*(4*c + 1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[8*(4*c + 2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[8*(4*c + 3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic blk_t mid_round(input blk_t s, input blk_t k);
        return mix_columns(shift_rows(sub_bytes(s))) ^ k;
    endfunction

    function automatic blk_t final_round(input blk_t s, input blk_t k);
        return shift_rows(sub_bytes(s)) ^ k;
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block handshake bundle between the UART framers and the AES engine.
//   master : framer side (drives in_valid/in_data/in_key/out_ready)
//   slave  : engine side (drives in_ready/out_valid/out_data/busy)
interface aes_round_ctrl_if;

    logic                         in_valid;
    logic                         in_ready;
    logic [0:aes_pkg::BLK_W-1]    in_data;
    logic [0:aes_pkg::BLK_W-1]    in_key;
    logic                         out_valid;
    logic                         out_ready;
    logic [0:aes_pkg::BLK_W-1]    out_data;
    logic                         busy;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/aes_key_step.sv
// AES-128 key schedule step: next round key from current key and rcon.
//   i_key   : current round key, FIPS-197 byte order
//   i_rcon  : round constant for this step
//   o_key_c : next round key (combinational)
module aes_key_step
    import aes_pkg::*;
(
    input  blk_t       i_key,
    input  logic [7:0] i_rcon,
    output blk_t       o_key_c
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_sub, w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    // Word j holds key bytes 4j..4j+3, byte 4j in the MSBs.
    assign w_w0 = i_key[0:31];
    assign w_w1 = i_key[32:63];
    assign w_w2 = i_key[64:95];
    assign w_w3 = i_key[96:127];

    assign w_rot  = {w_w3[23:0], w_w3[31:24]};
    assign w_sub  = {SBOX[w_rot[31:24]], SBOX[w_rot[23:16]],
                     SBOX[w_rot[15:8]],  SBOX[w_rot[7:0]]};
    assign w_temp = w_sub ^ {i_rcon, 24'h000000};

    assign w_n0 = w_w0 ^ w_temp;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_key_c = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock, on-the-fly
// key expansion, valid/ready handshake on both sides.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : aes_round_ctrl_if.slave (in_valid/in_ready/in_data/in_key,
//                out_valid/out_ready/out_data, busy)
//   dbg_round, dbg_rkey : present only when AES_ROUND_CTRL_DBG_EN is defined
module aes_round_ctrl
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef AES_ROUND_CTRL_DBG_EN
    output logic [3:0]           dbg_round,
    output logic [0:BLK_W-1]     dbg_rkey,
`endif
    aes_round_ctrl_if.slave      bus
);

    aes_state_e r_fsm;
    blk_t       r_state;
    blk_t       r_rkey;
    logic [7:0] r_rcon;
    logic [3:0] r_round;
    logic       r_in_ready;
    logic       r_out_valid;
    logic       r_busy;

    blk_t       w_nk;
    blk_t       w_mid;
    blk_t       w_fin;

    aes_key_step u_key_step (
        .i_key   (r_rkey),
        .i_rcon  (r_rcon),
        .o_key_c (w_nk)
    );

    assign w_mid = mid_round(r_state, w_nk);
    assign w_fin = final_round(r_state, w_nk);

    // Control FSM and datapath registers; handshake flags are registered
    // alongside the state so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= AES_IDLE;
            r_state     <= '0;
            r_rkey      <= '0;
            r_rcon      <= 8'h00;
            r_round     <= 4'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                AES_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_state    <= bus.in_data ^ bus.in_key;
                        r_rkey     <= bus.in_key;
                        r_rcon     <= RCON_INIT;
                        r_round    <= 4'd1;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_fsm      <= AES_ROUND;
                    end
                end
                AES_ROUND: begin
                    r_state <= w_mid;
                    r_rkey  <= w_nk;
                    r_rcon  <= xtime(r_rcon);
                    r_round <= r_round + 4'd1;
                    if (r_round == 4'(NUM_ROUNDS - 1)) begin
                        r_fsm <= AES_FINAL;
                    end
                end
                AES_FINAL: begin
                    r_state     <= w_fin;
                    r_out_valid <= 1'b1;
                    r_fsm       <= AES_DONE;
                end
                AES_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_fsm       <= AES_IDLE;
                    end
                end
                default: begin
                    r_fsm <= AES_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_state;
    assign bus.busy      = r_busy;

`ifdef AES_ROUND_CTRL_DBG_EN
    assign dbg_round = r_round;
    assign dbg_rkey  = r_rkey;
`endif

    // The round counter must stay within 0..NUM_ROUNDS (15 would mean a runaway).
    a_round_range: assert property (@(posedge clk) disable iff (!rst_n)
                                     (r_round <= 4'(NUM_ROUNDS)) && (r_round != 4'd15))
        else $error("round counter out of range: %0d", r_round);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl using FIPS-197 App. B and App. C.1.
module tb_aes_round_ctrl;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   cyc;

`ifdef AES_ROUND_CTRL_DBG_EN
    logic [3:0]   dbg_round;
    logic [0:127] dbg_rkey;
`endif

    aes_round_ctrl_if bus ();

    aes_round_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef AES_ROUND_CTRL_DBG_EN
        .dbg_round (dbg_round),
        .dbg_rkey  (dbg_rkey),
`endif
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one block, wait for out_valid, check latency and ciphertext.
    task automatic run_block(input string tag, input logic [127:0] pt,
                             input logic [127:0] key, input logic [127:0] ct,
                             input bit toggle);
        int lat;
        check({tag, "_idle_ready"}, 128'(bus.in_ready), 128'(1));
        bus.in_valid = 1'b1;
        bus.in_data  = pt;
        bus.in_key   = key;
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_accept_ready"}, 128'(bus.in_ready), 128'(0));
        check({tag, "_accept_busy"}, 128'(bus.busy), 128'(1));
`ifdef AES_ROUND_CTRL_DBG_EN
        check({tag, "_dbg_round"}, 128'(dbg_round), 128'(1));
        check({tag, "_dbg_rkey"}, dbg_rkey, key);
`endif
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            if (toggle) begin
                bus.in_valid = 1'($urandom_range(1, 0));
                bus.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
                bus.in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            tick();
            lat++;
        end
        bus.in_valid = 1'b0;
        check({tag, "_latency"}, 128'(lat), 128'(10));
        check({tag, "_data"}, bus.out_data, ct);
    endtask

    // Hold out_ready low for 'hold' cycles, then perform one handshake.
    task automatic finish_block(input string tag, input int hold, input logic [127:0] ct);
        bus.out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            tick();
            check({tag, "_bp_stable"}, bus.out_data, ct);
        end
        if (hold > 0) begin
            check({tag, "_bp_valid"}, 128'(bus.out_valid), 128'(1));
            check({tag, "_bp_ready"}, 128'(bus.in_ready), 128'(0));
            check({tag, "_bp_busy"}, 128'(bus.busy), 128'(1));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_hs_valid"}, 128'(bus.out_valid), 128'(0));
        check({tag, "_hs_ready"}, 128'(bus.in_ready), 128'(1));
        check({tag, "_hs_busy"}, 128'(bus.busy), 128'(0));
        tick();
        check({tag, "_post_valid"}, 128'(bus.out_valid), 128'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
        check({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
        check({tag, "_busy"}, 128'(bus.busy), 128'(0));
        check({tag, "_out_data"}, bus.out_data, 128'h0);
`ifdef AES_ROUND_CTRL_DBG_EN
        check({tag, "_dbg_round"}, 128'(dbg_round), 128'(0));
        check({tag, "_dbg_rkey"}, dbg_rkey, 128'h0);
`endif
    endtask

    initial begin
        logic [127:0] res [2];
        int           t_acc [2];
        int           n_acc;
        int           n_out;
        bit           was_ready;

        n_cmp = 0;
        n_err = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("rst_rel");

        // App. B with immediate handshake
        run_block("vecB", PT_B, KEY_B, CT_B, 1'b0);
        finish_block("vecB", 0, CT_B);

        // App. C.1 with 20 cycles of backpressure
        run_block("vecC", PT_C, KEY_C, CT_C, 1'b0);
        finish_block("vecC", 20, CT_C);

        // Input activity during rounds is ignored
        run_block("tog", PT_B, KEY_B, CT_B, 1'b1);
        finish_block("tog", 2, CT_B);

        // Reset mid-operation, then a clean App. C.1 run
        bus.in_valid = 1'b1;
        bus.in_data  = PT_B;
        bus.in_key   = KEY_B;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("midrst_busy_before", 128'(bus.busy), 128'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        #2 rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("midrst_no_valid", 128'(bus.out_valid), 128'(0));
        run_block("postrst", PT_C, KEY_C, CT_C, 1'b0);
        finish_block("postrst", 0, CT_C);

        // Back-to-back blocks with out_ready tied high
        n_acc = 0;
        n_out = 0;
        t_acc[0] = 0;
        t_acc[1] = 0;
        res[0] = '0;
        res[1] = '0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = PT_B;
        bus.in_key    = KEY_B;
        for (int k = 0; k < 60 && n_out < 2; k++) begin
            was_ready = bus.in_ready;
            tick();
            if (was_ready && bus.in_valid && n_acc < 2) begin
                t_acc[n_acc] = cyc;
                n_acc++;
                bus.in_data = PT_C;
                bus.in_key  = KEY_C;
                if (n_acc == 2) bus.in_valid = 1'b0;
            end
            if (bus.out_valid && n_out < 2) begin
                res[n_out] = bus.out_data;
                n_out++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_accepts", 128'(n_acc), 128'(2));
        check("b2b_results", 128'(n_out), 128'(2));
        check("b2b_period", 128'(t_acc[1] - t_acc[0]), 128'(12));
        check("b2b_ct0", res[0], CT_B);
        check("b2b_ct1", res[1], CT_C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption engine controller. Wraps one combinational middle-round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) and one final-round datapath (no MixColumns). Sequences them over 10 rounds with on-the-fly key expansion. Sits between the UART receive framer, which supplies the plaintext and key, and the UART transmit framer, which takes the ciphertext, using valid/ready handshakes on both sides.

## Interface
Parameters:
- none; AES-128 only, round count fixed by package constant `NUM_ROUNDS` = 10

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  plaintext and key are present
- `in_ready`  out  1  engine can accept a block; high only in IDLE
- `in_data`  in  [0:127]  plaintext; byte 0 = bits 0:7 (FIPS-197 order)
- `in_key`  in  [0:127]  cipher key, same byte order
- `out_valid`  out  1  ciphertext is available
- `out_ready`  in  1  downstream accepts the ciphertext
- `out_data`  out  [0:127]  ciphertext; driven directly from the state register
- `busy`  out  1  high in ROUND, FINAL and DONE

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE → ROUND on `in_valid && in_ready`. At that edge:
  - `state <= in_data ^ in_key`
  - `rkey <= in_key`
  - `rcon <= 8'h01`
  - `round <= 1`
- In ROUND, each cycle:
  - `nk = key_step(rkey, rcon)`
  - `state <= mid_round(state, nk)`
  - `rkey <= nk`
  - `rcon <= xtime(rcon)`
  - `round <= round + 1`
  - ROUND → FINAL at the edge where `round == 9`.
- In FINAL: `state <= final_round(state, key_step(rkey, rcon))`, then → DONE.
- Required `rcon` sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. `xtime` is a left shift, XORed with `8'h1b` when bit 7 was set.
- DONE holds `out_valid = 1` and keeps `out_data` stable until `out_valid && out_ready`. On that edge → IDLE.
- `in_data` and `in_key` are sampled only at acceptance. Changes afterwards have no effect.
- `in_valid` outside IDLE is ignored; `in_ready` is 0 there.
- `round` is a 4-bit counter. It never exceeds 10; reaching 15 is a design error and must be flagged by an assertion.

## Timing
- Reset values (asynchronous, on `rst_n` low):
  - FSM = IDLE, `in_ready` = 1, `out_valid` = 0, `busy` = 0
  - `out_data` = 0, `rkey` = 0, `rcon` = 0, `round` = 0
- Latency: acceptance at edge t0. Mid rounds occur at t1..t9, the final round at t10. `out_valid` is high from t10.
- Minimum block period is 12 cycles: 11 edges to DONE, the output handshake edge, then acceptance is possible on the next edge.
- Output handshake with `out_ready` already high: DONE → IDLE at t11, and `in_ready` is high after t11.
- Backpressure: `out_ready` low for N cycles holds DONE. `out_data` does not change.
- Reset mid-operation: the engine aborts immediately. No `out_valid` pulse appears and the partial state is discarded. After reset release, the first accepted block behaves exactly as from a clean reset.
- Outputs are registered or are decodes of FSM state only. There is no combinational path from `in_*` to `out_*`.

## Configuration
- Macro: `AES_ROUND_CTRL_DBG_EN`.
- Defined: adds output ports `dbg_round [3:0]` (the current `round` value) and `dbg_rkey [0:127]` (the current round key register). Both reset to 0 and update on the same edges as the internal registers.
- Undefined: the ports are absent. Core behaviour and timing are identical in both builds.

## Structure
- Shared package `aes_pkg` holds:
  - FSM state enum (`AES_IDLE`, `AES_ROUND`, `AES_FINAL`, `AES_DONE`)
  - `NUM_ROUNDS` = 10
  - `RCON_INIT` = 8'h01
  - the `xtime` function
- One sub-module, `aes_key_step`: combinational, computes the next round key from the current key and `rcon`. It contains RotWord, SubWord (4 S-boxes) and the XOR chain.
- The round datapaths instantiate the team's existing substitution, shift-rows, mix-column and add-round-key blocks. The final round omits mix-column.

## Test plan
- FIPS-197 App. B vector: plaintext `3243f6a8885a308d313198a2e0370734`, key `2b7e151628aed2a6abf7158809cf4f3c` → `out_data` = `3925841d02dc09fbdc118597196a0b32`, with `out_valid` first high exactly 10 edges after acceptance.
- FIPS-197 App. C.1 vector: plaintext `00112233445566778899aabbccddeeff`, key `000102030405060708090a0b0c0d0e0f` → `69c4e0d86a7b0430d8cdb78070b4c55a`.
- Backpressure: `out_ready` held low for 20 cycles after `out_valid` → `out_data` is stable, `in_ready` = 0, and the FSM is still in DONE. On release, a single handshake occurs and the FSM returns to IDLE.
- `in_valid` and random `in_data`/`in_key` toggling during rounds 1–10 → no effect. The result matches the App. B ciphertext.
- `rst_n` asserted at round 5 → all outputs are at their reset values immediately. The App. C.1 vector run afterwards produces the correct result with the correct latency.
- Back-to-back blocks with `out_ready` tied high → acceptances are exactly 12 cycles apart and both ciphertexts are correct.
